// File: rtl/seg7_pkg.sv
// Shared types and constants for the 2-digit seconds display scanner.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int DEZ_W   = 3;
   localparam int UNI_W   = 4;
   localparam int DEZ_MAX = 5;

   typedef enum logic [1:0] {
      S_UNI     = 2'd0,
      S_BLANK_A = 2'd1,
      S_DEZ     = 2'd2,
      S_BLANK_B = 2'd3
   } state_t;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_scan2_bcd_to_seg7.sv
// BCD digit to 7-segment pattern; anything above 9 renders as a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] val,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (val)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan2.sv
// Two-digit multiplexed 7-segment scanner with blanking gaps and per-frame digit snapshot.
// Optional leading-zero blanking of the tens digit via macro SEG7_LZB_EN.
module seg7_scan2
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV  = 4,
   parameter int BLANK_CYC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DEZ_W-1:0] dez,
   input  logic [UNI_W-1:0] uni,
   input  logic             load,
   output logic [6:0]       seg,
   output logic [1:0]       an,
   output logic             frame
);

   localparam int MAX_LEN = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx, len_m1;
   logic               last;

   logic [DEZ_W-1:0]   shadow_dez, disp_dez;
   logic [UNI_W-1:0]   shadow_uni, disp_uni;
   logic [6:0]         uni_pat, dez_raw, dez_pat;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_BLANK_B;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      len_m1   = CNT_W'(BLANK_CYC - 1);
      if (state == S_UNI || state == S_DEZ)
         len_m1 = CNT_W'(SCAN_DIV - 1);
      last   = (cnt == len_m1);
      cnt_nx = cnt + CNT_W'(1);
      if (last) begin
         cnt_nx = '0;
         case (state)
            S_UNI:     state_nx = S_BLANK_A;
            S_BLANK_A: state_nx = S_DEZ;
            S_DEZ:     state_nx = S_BLANK_B;
            S_BLANK_B: state_nx = S_UNI;
            default:   state_nx = S_BLANK_B;
         endcase
      end
   end

   // disp only refreshes at frame start so both digits always come from one snapshot
   always_ff @(posedge clk) begin
      if (!rst) begin
         shadow_dez <= '0;
         shadow_uni <= '0;
         disp_dez   <= '0;
         disp_uni   <= '0;
      end else begin
         if (load) begin
            shadow_dez <= dez;
            shadow_uni <= uni;
         end
         if (state == S_BLANK_B && last) begin
            disp_dez <= shadow_dez;
            disp_uni <= shadow_uni;
         end
      end
   end

   bcd_to_seg7 u_dec_uni (.val(disp_uni),         .seg(uni_pat));
   bcd_to_seg7 u_dec_dez (.val({1'b0, disp_dez}), .seg(dez_raw));

   // tens is only valid up to 5; the shared decoder cannot know that
   assign dez_pat = (disp_dez > DEZ_W'(DEZ_MAX)) ? SEG_DASH : dez_raw;

   always_comb begin
      seg   = SEG_OFF;
      an    = 2'b00;
      frame = 1'b0;
      case (state)
         S_UNI: begin
            an    = 2'b01;
            seg   = uni_pat;
            frame = (cnt == '0);
         end
         S_DEZ: begin
`ifdef SEG7_LZB_EN
            if (disp_dez != '0) begin
               an  = 2'b10;
               seg = dez_pat;
            end
`else
            an  = 2'b10;
            seg = dez_pat;
`endif
         end
         default: begin
            an  = 2'b00;
            seg = SEG_OFF;
         end
      endcase
   end

endmodule

// File: tb/tb_seg7_scan2.sv
// Directed bench for seg7_scan2 (SCAN_DIV=4, BLANK_CYC=1); expectations are hand-derived per frame.
// Also valid with SEG7_LZB_EN defined.
module tb_seg7_scan2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] dez = '0;
   logic [3:0] uni = '0;
   logic       load = 1'b0;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame;

   int checks = 0;
   int errors = 0;

   seg7_scan2 #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
      .clk(clk), .rst(rst), .dez(dez), .uni(uni), .load(load),
      .seg(seg), .an(an), .frame(frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] e_an,
                      input logic [6:0] e_seg, input logic e_fr);
      checks++;
      assert (an === e_an) else begin
         errors++;
         $error("FAIL %s an got %b exp %b", tag, an, e_an);
      end
      checks++;
      assert (seg === e_seg) else begin
         errors++;
         $error("FAIL %s seg got %h exp %h", tag, seg, e_seg);
      end
      checks++;
      assert (frame === e_fr) else begin
         errors++;
         $error("FAIL %s frame got %b exp %b", tag, frame, e_fr);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts in the S_BLANK_B cycle, checks 10 cycles, ends in the next S_BLANK_B.
   task automatic check_frame(input string tag, input logic [6:0] us, input logic [6:0] ds,
                              input logic [1:0] dan, input int ld_at,
                              input logic [2:0] ld_dez, input logic [3:0] ld_uni);
      logic [1:0] ea;
      logic [6:0] es;
      logic       ef;
      for (int i = 0; i < 10; i++) begin
         ea = 2'b00; es = 7'h00; ef = 1'b0;
         if (i >= 1 && i <= 4) begin
            ea = 2'b01; es = us; ef = (i == 1);
         end else if (i >= 6) begin
            ea = dan; es = (dan == 2'b00) ? 7'h00 : ds;
         end
         chk($sformatf("%s[%0d]", tag, i), ea, es, ef);
         if (i == ld_at) begin
            load = 1'b1; dez = ld_dez; uni = ld_uni;
         end
         tick();
         load = 1'b0;
      end
   endtask

   initial begin
      logic [1:0] lzb_an;
`ifdef SEG7_LZB_EN
      lzb_an = 2'b00;
`else
      lzb_an = 2'b10;
`endif
      // reset, then idle frames show 0/0
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_frame("idle0", 7'h3F, 7'h3F, 2'b10, -1, 3'd0, 4'd0);
      check_frame("idle1", 7'h3F, 7'h3F, 2'b10, -1, 3'd0, 4'd0);

      // load mid-S_DEZ: current frame unchanged, next shows 4/7
      check_frame("ldmid", 7'h3F, 7'h3F, 2'b10, 7, 3'd4, 4'd7);
      check_frame("show47", 7'h07, 7'h66, 2'b10, -1, 3'd0, 4'd0);

      // load on the frame boundary edge: old digits persist one more frame
      check_frame("ldedge", 7'h07, 7'h66, 2'b10, 0, 3'd5, 4'd9);
      check_frame("show59", 7'h6F, 7'h6D, 2'b10, -1, 3'd0, 4'd0);

      // invalid digits render as dashes
      check_frame("ldbad", 7'h6F, 7'h6D, 2'b10, 3, 3'd6, 4'd12);
      check_frame("dash", 7'h40, 7'h40, 2'b10, -1, 3'd0, 4'd0);

      // reset in S_UNI count 2, with a competing load
      chk("rst.b", 2'b00, 7'h00, 1'b0); tick();
      chk("rst.u0", 2'b01, 7'h40, 1'b1); tick();
      chk("rst.u1", 2'b01, 7'h40, 1'b0); tick();
      chk("rst.u2", 2'b01, 7'h40, 1'b0);
      rst = 1'b0; load = 1'b1; dez = 3'd3; uni = 4'd3;
      tick();
      rst = 1'b1; load = 1'b0;
      check_frame("post0", 7'h3F, 7'h3F, 2'b10, -1, 3'd0, 4'd0);
      check_frame("post1", 7'h3F, 7'h3F, 2'b10, -1, 3'd0, 4'd0);

      // tens zero: blanked with leading-zero blanking, "0" otherwise
      check_frame("ld05", 7'h3F, 7'h3F, 2'b10, 2, 3'd0, 4'd5);
      check_frame("lzb", 7'h6D, 7'h3F, lzb_an, -1, 3'd0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan2.md
Name: seg7_scan2

Overview:
- Downstream display stage for the 00–59 seconds counter.
- Consumes the counter's BCD tens (3-bit) and units (4-bit) digits.
- Drives a 2-digit multiplexed 7-segment display: scan FSM, anti-ghost blanking gaps, frame-consistent snapshot of the digits.
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 4, clock cycles each digit is lit per frame (>=1).
- BLANK_CYC, 1, clock cycles all digits are dark between digit phases (>=1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- dez  input  3  BCD tens digit from seconds counter.
- uni  input  4  BCD units digit from seconds counter.
- load  input  1  sample strobe; when 1, dez/uni are captured into the shadow register.
- seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- an  output  2  digit enable, active-high; an[0]=units, an[1]=tens; at most one bit set.
- frame  output  1  one-cycle pulse in the first cycle of each S_UNI phase.

Behaviour:
- Reset: one clock with rst=0 sets state=S_BLANK_B, phase counter=0, shadow={0,0}, disp={0,0}. While state is S_BLANK_B: seg=7'h00, an=2'b00, frame=0.
- Outputs are Moore: decoded only from registered state and the disp register, never from inputs.
- FSM cycles S_UNI -> S_BLANK_A -> S_DEZ -> S_BLANK_B -> S_UNI.
  - S_UNI and S_DEZ last SCAN_DIV cycles each.
  - Blank states last BLANK_CYC cycles each.
  - Phase counter counts 0..len-1, clears on every state change.
  - Frame period = 2*(SCAN_DIV+BLANK_CYC) cycles.
- Outputs per state:
  - S_UNI: an=01, seg=decode(disp_uni).
  - S_DEZ: an=10, seg=decode(disp_dez).
  - Blank states: an=00, seg=00.
- frame=1 exactly in the cycle where state=S_UNI and counter=0.
- Shadow: load=1 captures dez/uni at that edge; otherwise shadow holds.
- Disp: copied from shadow only on the S_BLANK_B->S_UNI edge. Digits never change mid-frame.
- load on that same edge: disp takes the old shadow; the new value shows next frame. Latency from load to display is therefore at most one frame plus one blank phase.
- Decode: 0..9 -> 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- Invalid input shows a dash (7'h40), not an error:
  - units value 10–15 -> dash.
  - tens value 6–7 -> dash.
  - disp keeps the raw value; only the decode substitutes the dash.
- rst=0 mid-frame: next edge forces the reset state regardless of state or load.

Optional Feature:
- Macro SEG7_LZB_EN (leading-zero blanking).
- Defined: during S_DEZ with disp_dez==0, an=00 and seg=00. Timing is unchanged, S_DEZ still lasts SCAN_DIV cycles.
- Undefined: tens digit 0 displays "0" (seg=3F, an=10).

Decomposition:
- Shared package seg7_pkg:
  - state enum {S_UNI,S_BLANK_A,S_DEZ,S_BLANK_B}.
  - localparams SEG_0..SEG_9, SEG_DASH, SEG_OFF.
  - function widths: DEZ_W=3, UNI_W=4.
- One natural sub-module: bcd_to_seg7, a 4-bit value to 7-bit pattern decoder with a dash for values >9. It is instantiated twice; tens input is zero-extended and gets an extra >5 check in the parent.

Test Plan (SCAN_DIV=4, BLANK_CYC=1, frame=10 cycles):
- Reset then rst=1, no load -> 1 cycle an=00; 4 cycles an=01 seg=3F with frame=1 on first only; 1 cycle an=00; 4 cycles an=10 seg=3F; repeats every 10 cycles.
- load=1 with dez=4 uni=7 mid-S_DEZ -> current frame unchanged; next frame shows units seg=07, tens seg=66.
- load pulse exactly on the S_BLANK_B->S_UNI edge with dez=5 uni=9 -> that frame shows old digits; the following frame shows 6F/6D.
- dez=6 uni=12 loaded -> both digits seg=40; the an sequence is unchanged.
- rst=0 for 1 cycle during S_UNI count 2 -> next cycle an=00 seg=00; shadow and disp are 0; restart sequence matches test 1.
- SEG7_LZB_EN defined, dez=0 uni=5 -> units seg=6D an=01; tens phase an=00 seg=00 for 4 cycles.
